// File: rtl/dp_pkg.sv
// Shared types and constants for the DP control sequencer.
package dp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [1:0] SEL_IN1 = 2'b11;
  localparam logic [1:0] SEL_IN2 = 2'b10;
  localparam logic [1:0] SEL_ALU = 2'b00;

  localparam logic [1:0] OP_ADD = 2'b11;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b00;

endpackage

// File: rtl/dp_ctrl.sv
// Sequencer driving the register-file/ALU datapath: load in1, load in2, execute, optional write-back.
// Write-back state is built only when DPC_WB_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start; all controls at idle values
// LOAD_A | in1 written to addr_a
// LOAD_B | in2 written to addr_b
// EXEC   | both ports read, ALU result driven to out
// WB     | ALU result written to addr_d (DPC_WB_EN only)
// DONE   | one-cycle done pulse
module dp_ctrl
  import dp_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int OP_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_d,
  output logic              busy,
  output logic              done,
  output logic [1:0]        s1,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic              rea,
  output logic              reb,
  output logic [ADDR_W-1:0] raa,
  output logic [ADDR_W-1:0] rab,
  output logic [OP_W-1:0]   c,
  output logic              s2
);

  state_t            state, next_state;
  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] a_q, b_q;
  logic              accept;

  assign accept = (state == IDLE) && start;

`ifdef DPC_WB_EN
  logic [ADDR_W-1:0] d_q;

  always_ff @(posedge clk) begin
    if (!rst_n)      d_q <= '0;
    else if (accept) d_q <= addr_d;
  end
`else
  logic unused_addr_d;
  assign unused_addr_d = ^addr_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        op_q <= op;
        a_q  <= addr_a;
        b_q  <= addr_b;
      end
    end
  end

  always_comb begin
    next_state = state;
    busy = 1'b0;
    done = 1'b0;
    s1   = SEL_ALU;
    we   = 1'b0;
    wa   = '0;
    rea  = 1'b0;
    reb  = 1'b0;
    raa  = '0;
    rab  = '0;
    c    = '0;
    s2   = 1'b0;
    case (state)
      IDLE: if (start) next_state = LOAD_A;
      LOAD_A: begin
        busy = 1'b1;
        s1   = SEL_IN1;
        we   = 1'b1;
        wa   = a_q;
        next_state = LOAD_B;
      end
      LOAD_B: begin
        busy = 1'b1;
        s1   = SEL_IN2;
        we   = 1'b1;
        wa   = b_q;
        next_state = EXEC;
      end
      EXEC: begin
        busy = 1'b1;
        rea  = 1'b1;
        reb  = 1'b1;
        raa  = a_q;
        rab  = b_q;
        c    = op_q;
        s2   = 1'b1;
`ifdef DPC_WB_EN
        next_state = WB;
`else
        next_state = DONE;
`endif
      end
`ifdef DPC_WB_EN
      // Read ports stay live so the ALU result is still valid while it is written.
      WB: begin
        busy = 1'b1;
        s1   = SEL_ALU;
        we   = 1'b1;
        wa   = d_q;
        rea  = 1'b1;
        reb  = 1'b1;
        raa  = a_q;
        rab  = b_q;
        c    = op_q;
        next_state = DONE;
      end
`endif
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dp_ctrl.sv
// Scoreboard bench for dp_ctrl with a small behavioural datapath model attached.
module tb_dp_ctrl;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] s1;
    logic       we;
    logic [1:0] wa;
    logic       rea;
    logic       reb;
    logic [1:0] raa;
    logic [1:0] rab;
    logic [1:0] c;
    logic       s2;
    logic [2:0] out;
  } ctl_t;

`ifdef DPC_WB_EN
  localparam int LEN = 5;
`else
  localparam int LEN = 4;
`endif

  localparam logic [2:0] IN1 = 3'b110;
  localparam logic [2:0] IN2 = 3'b010;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [1:0] op, addr_a, addr_b, addr_d;
  logic       busy, done, we, rea, reb, s2;
  logic [1:0] s1, wa, raa, rab, c;

  int checks = 0;
  int errors = 0;
  ctl_t exp_q[$];

  always #5 clk = ~clk;

  dp_ctrl #(.ADDR_W(2), .OP_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d),
    .busy(busy), .done(done), .s1(s1), .we(we), .wa(wa),
    .rea(rea), .reb(reb), .raa(raa), .rab(rab), .c(c), .s2(s2)
  );

  // Behavioural datapath: 4x3 register file, ALU, input and output muxes.
  logic [2:0] rf [4];
  logic [2:0] a_val, b_val, alu, wdata, dp_out;

  initial for (int i = 0; i < 4; i++) rf[i] = 3'b000;

  always_comb begin
    a_val = rea ? rf[raa] : 3'b000;
    b_val = reb ? rf[rab] : 3'b000;
    case (c)
      2'b11:   alu = a_val + b_val;
      2'b10:   alu = a_val - b_val;
      2'b01:   alu = a_val & b_val;
      default: alu = a_val ^ b_val;
    endcase
    case (s1)
      2'b11:   wdata = IN1;
      2'b10:   wdata = IN2;
      default: wdata = alu;
    endcase
    dp_out = s2 ? alu : 3'b000;
  end

  always @(posedge clk) if (we === 1'b1) rf[wa] <= wdata;

  function automatic ctl_t idle_v();
    ctl_t v = '0;
    return v;
  endfunction

  task automatic check(input string name, input ctl_t act, input ctl_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  // Monitor: every busy cycle consumes one expected vector; idle cycles must show idle values.
  initial begin
    ctl_t act, e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      act = '{busy:busy, done:done, s1:s1, we:we, wa:wa, rea:rea, reb:reb,
              raa:raa, rab:rab, c:c, s2:s2, out:dp_out};
      if (busy === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_busy: got %b required no busy cycle (t=%0t)", act, $time);
        end else begin
          e = exp_q.pop_front();
          check("busy_cycle", act, e);
        end
      end else begin
        check("idle_cycle", act, idle_v());
      end
    end
  end

  // Called in an IDLE cycle; returns one cycle later (in LOAD_A) with inputs scrambled.
  task automatic issue(input logic [1:0] o, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] d, input logic [2:0] eo, input bit abort);
    ctl_t v;
    start = 1'b1; op = o; addr_a = a; addr_b = b; addr_d = d;
    v = '0; v.busy = 1; v.s1 = 2'b11; v.we = 1; v.wa = a;        exp_q.push_back(v);
    v = '0; v.busy = 1; v.s1 = 2'b10; v.we = 1; v.wa = b;        exp_q.push_back(v);
    v = '0; v.busy = 1; v.rea = 1; v.reb = 1; v.raa = a; v.rab = b;
    v.c = o; v.s2 = 1; v.out = eo;                                exp_q.push_back(v);
    if (!abort) begin
`ifdef DPC_WB_EN
      v = '0; v.busy = 1; v.s1 = 2'b00; v.we = 1; v.wa = d;
      v.rea = 1; v.reb = 1; v.raa = a; v.rab = b; v.c = o;        exp_q.push_back(v);
`endif
      v = '0; v.busy = 1; v.done = 1;                             exp_q.push_back(v);
    end
    @(posedge clk); #1;
    start = 1'b0; op = ~o; addr_a = ~a; addr_b = ~b; addr_d = ~d;
  endtask

  task automatic finish_op();
    repeat (LEN) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b1; op = 2'b11; addr_a = 2'b01; addr_b = 2'b10; addr_d = 2'b11;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; start = 1'b0;

    // One op per ALU function with in1=110, in2=010.
    issue(2'b00, 2'b01, 2'b10, 2'b00, 3'b100, 0); finish_op();
    issue(2'b11, 2'b01, 2'b10, 2'b00, 3'b000, 0); finish_op();
    issue(2'b10, 2'b01, 2'b10, 2'b00, 3'b100, 0); finish_op();
    issue(2'b01, 2'b01, 2'b10, 2'b00, 3'b010, 0); finish_op();

    // start in LOAD_B and in DONE is ignored; start in the following IDLE cycle is taken.
    issue(2'b00, 2'b10, 2'b01, 2'b00, 3'b100, 0);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (LEN - 3) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1;
    issue(2'b11, 2'b01, 2'b10, 2'b00, 3'b000, 0); finish_op();

    // Write-back of AND into r3: only the WB build may touch r3.
    issue(2'b01, 2'b00, 2'b01, 2'b11, 3'b010, 0); finish_op();
`ifdef DPC_WB_EN
    check3("rf3_after_wb", rf[3], 3'b010);
`else
    check3("rf3_untouched", rf[3], 3'b000);
`endif

    // Same source on both ports: LOAD_B overwrites, both ports read in2.
    issue(2'b01, 2'b11, 2'b11, 2'b10, 3'b010, 0); finish_op();
    issue(2'b00, 2'b11, 2'b11, 2'b10, 3'b000, 0); finish_op();

    // Reset during EXEC: no done pulse, then a clean op afterwards.
    issue(2'b10, 2'b01, 2'b10, 2'b00, 3'b100, 1);
    @(posedge clk); #1;
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    issue(2'b01, 2'b10, 2'b01, 2'b00, 3'b010, 0); finish_op();

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending vectors required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
